sdc_req_sched: RTL and testbench

- Front-end scheduler for the SDR/DDR controller address path. It shares one `sdr_req`/`u_addr` channel between three host requesters using round-robin arbitration, and it interleaves auto-refresh requests from an internal interval timer.
- It drives the controller request fields (`sdr_req`, `sdr_req_wr_n`, `u_addr`, `bl`) and holds them stable for a whole transfer.
- It guarantees a low gap on `sdr_req` between transactions, because the address latch starts each transfer on the rising edge of `sdr_req`.

---
 rtl/sdc_req_sched.sv | 226 ++++++++++++++++++++++
 tb/tb_sdc_req_sched.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdc_req_sched.sv
// sdc_req_sched: three-way host arbiter and auto-refresh scheduler for the SDR/DDR address path.
// Define SDC_SCHED_FIXED_PRIO_EN for fixed priority 0 > 1 > 2 instead of round-robin.
module sdc_req_sched #(
    parameter int ADDR_W       = 23,
    parameter int REF_INTERVAL = 1560,
    parameter int REF_PEND_MAX = 7
) (
    input  logic                  clk,
    input  logic                  reset1_n,
    input  logic                  init_done,
    input  logic [2:0]            req,
    input  logic [2:0]            req_wr_n,
    input  logic [3*ADDR_W-1:0]   req_addr,
    input  logic [26:0]           req_bl,
    output logic [2:0]            gnt,
    output logic [1:0]            gnt_id,
    output logic                  sdr_req,
    output logic                  sdr_req_wr_n,
    output logic [ADDR_W-1:0]     u_addr,
    output logic [8:0]            bl,
    input  logic                  xfer_done,
    output logic                  ref_req,
    input  logic                  ref_ack,
    output logic                  ref_ovf
);

    localparam int CNT_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(REF_INTERVAL - 1);
    localparam logic [2:0] PEND_MAX = 3'(REF_PEND_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_REF  = 2'd2,
        S_GAP  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        gnt_q, gnt_d;
    logic [1:0]        gnt_id_q, gnt_id_d;
    logic              sdr_req_q, sdr_req_d;
    logic              sdr_req_wr_n_q, sdr_req_wr_n_d;
    logic [ADDR_W-1:0] u_addr_q, u_addr_d;
    logic [8:0]        bl_q, bl_d;
    logic              ref_req_q, ref_req_d;
    logic              ref_ovf_q, ref_ovf_d;
    logic [CNT_W-1:0]  ref_cnt_q, ref_cnt_d;
    logic [2:0]        ref_pend_q, ref_pend_d;

    logic       win_vld;
    logic [1:0] win_id;
    logic       grant_now;
    logic       ref_tick;
    logic       ref_done;

`ifdef SDC_SCHED_FIXED_PRIO_EN
    always_comb begin
        win_vld = |req;
        win_id  = 2'd0;
        if (req[0]) begin
            win_id = 2'd0;
        end else if (req[1]) begin
            win_id = 2'd1;
        end else if (req[2]) begin
            win_id = 2'd2;
        end
    end
`else
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [1:0] cand1, cand2;

    function automatic logic [1:0] rr_next(input logic [1:0] p);
        return (p >= 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Search starts just after the last owner; the last owner is tried last.
    always_comb begin
        cand1   = rr_next(rr_ptr_q);
        cand2   = rr_next(cand1);
        win_vld = |req;
        win_id  = rr_ptr_q;
        if (req[cand1]) begin
            win_id = cand1;
        end else if (req[cand2]) begin
            win_id = cand2;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_now) begin
            rr_ptr_d = win_id;
        end
    end

    always_ff @(posedge clk or negedge reset1_n) begin
        if (!reset1_n) begin
            rr_ptr_q <= 2'd2;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    assign grant_now = init_done && (state_q == S_IDLE) &&
                       (ref_pend_q == 3'd0) && win_vld;
    assign ref_tick  = (ref_cnt_q == '0);
    assign ref_done  = (state_q == S_REF) && ref_ack;

    // Refresh timer and pending-token counter.
    always_comb begin
        ref_cnt_d  = ref_cnt_q;
        ref_pend_d = ref_pend_q;
        ref_ovf_d  = ref_ovf_q;
        if (!init_done) begin
            ref_cnt_d  = CNT_RELOAD;
            ref_pend_d = 3'd0;
        end else begin
            ref_cnt_d = ref_tick ? CNT_RELOAD : ref_cnt_q - 1'b1;
            if (ref_tick && !ref_done) begin
                if (ref_pend_q == PEND_MAX) begin
                    ref_ovf_d = 1'b1;
                end else begin
                    ref_pend_d = ref_pend_q + 3'd1;
                end
            end else if (!ref_tick && ref_done) begin
                ref_pend_d = ref_pend_q - 3'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (!init_done) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (ref_pend_q != 3'd0) begin
                        state_d = S_REF;
                    end else if (grant_now) begin
                        state_d = S_BUSY;
                    end
                end
                S_BUSY:  if (xfer_done) state_d = S_GAP;
                S_REF:   if (ref_ack) state_d = S_GAP;
                S_GAP:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        gnt_d          = 3'b000;
        gnt_id_d       = gnt_id_q;
        sdr_req_d      = sdr_req_q;
        sdr_req_wr_n_d = sdr_req_wr_n_q;
        u_addr_d       = u_addr_q;
        bl_d           = bl_q;
        ref_req_d      = ref_req_q;
        if (!init_done) begin
            sdr_req_d = 1'b0;
            ref_req_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (ref_pend_q != 3'd0) begin
                        ref_req_d = 1'b1;
                    end else if (grant_now) begin
                        gnt_d          = 3'b001 << win_id;
                        gnt_id_d       = win_id;
                        sdr_req_d      = 1'b1;
                        sdr_req_wr_n_d = req_wr_n[win_id];
                        u_addr_d       = req_addr[int'(win_id)*ADDR_W +: ADDR_W];
                        bl_d           = req_bl[int'(win_id)*9 +: 9];
                    end
                end
                S_BUSY: if (xfer_done) sdr_req_d = 1'b0;
                S_REF:  if (ref_ack) ref_req_d = 1'b0;
                S_GAP: begin
                    sdr_req_d = 1'b0;
                    ref_req_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset1_n) begin
        if (!reset1_n) begin
            state_q        <= S_IDLE;
            gnt_q          <= 3'b000;
            gnt_id_q       <= 2'd0;
            sdr_req_q      <= 1'b0;
            sdr_req_wr_n_q <= 1'b0;
            u_addr_q       <= '0;
            bl_q           <= 9'd0;
            ref_req_q      <= 1'b0;
            ref_ovf_q      <= 1'b0;
            ref_cnt_q      <= CNT_RELOAD;
            ref_pend_q     <= 3'd0;
        end else begin
            state_q        <= state_d;
            gnt_q          <= gnt_d;
            gnt_id_q       <= gnt_id_d;
            sdr_req_q      <= sdr_req_d;
            sdr_req_wr_n_q <= sdr_req_wr_n_d;
            u_addr_q       <= u_addr_d;
            bl_q           <= bl_d;
            ref_req_q      <= ref_req_d;
            ref_ovf_q      <= ref_ovf_d;
            ref_cnt_q      <= ref_cnt_d;
            ref_pend_q     <= ref_pend_d;
        end
    end

    assign gnt          = gnt_q;
    assign gnt_id       = gnt_id_q;
    assign sdr_req      = sdr_req_q;
    assign sdr_req_wr_n = sdr_req_wr_n_q;
    assign u_addr       = u_addr_q;
    assign bl           = bl_q;
    assign ref_req      = ref_req_q;
    assign ref_ovf      = ref_ovf_q;

endmodule

// File: tb/tb_sdc_req_sched.sv
// Directed bench for sdc_req_sched: arbitration, gap timing, refresh
// interleave, refresh saturation and asynchronous reset.
module tb_sdc_req_sched;

    localparam int AW = 23;
`ifdef SDC_SCHED_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset1_n;
    logic            init_done;
    logic [2:0]      req;
    logic [2:0]      req_wr_n;
    logic [3*AW-1:0] req_addr;
    logic [26:0]     req_bl;
    logic [2:0]      gnt;
    logic [1:0]      gnt_id;
    logic            sdr_req;
    logic            sdr_req_wr_n;
    logic [AW-1:0]   u_addr;
    logic [8:0]      bl;
    logic            xfer_done;
    logic            ref_req;
    logic            ref_ack;
    logic            ref_ovf;
    logic            auto_ack = 1'b0;

    logic            init_done_s;
    logic            ref_ack_s;
    logic [2:0]      gnt_s;
    logic [1:0]      gnt_id_s;
    logic            sdr_req_s;
    logic            sdr_req_wr_n_s;
    logic [AW-1:0]   u_addr_s;
    logic [8:0]      bl_s;
    logic            ref_req_s;
    logic            ref_ovf_s;

    int n_chk  = 0;
    int n_fail = 0;

    logic [AW-1:0] exp_addr [3];
    logic [8:0]    exp_bl   [3];
    logic          exp_wr_n [3];

    sdc_req_sched #(.ADDR_W(AW), .REF_INTERVAL(16), .REF_PEND_MAX(7)) u_dut (
        .clk(clk), .reset1_n(reset1_n), .init_done(init_done),
        .req(req), .req_wr_n(req_wr_n), .req_addr(req_addr), .req_bl(req_bl),
        .gnt(gnt), .gnt_id(gnt_id), .sdr_req(sdr_req),
        .sdr_req_wr_n(sdr_req_wr_n), .u_addr(u_addr), .bl(bl),
        .xfer_done(xfer_done), .ref_req(ref_req), .ref_ack(ref_ack),
        .ref_ovf(ref_ovf)
    );

    sdc_req_sched #(.ADDR_W(AW), .REF_INTERVAL(40), .REF_PEND_MAX(7)) u_sat (
        .clk(clk), .reset1_n(reset1_n), .init_done(init_done_s),
        .req(3'b000), .req_wr_n(3'b111), .req_addr({3*AW{1'b0}}),
        .req_bl(27'd0),
        .gnt(gnt_s), .gnt_id(gnt_id_s), .sdr_req(sdr_req_s),
        .sdr_req_wr_n(sdr_req_wr_n_s), .u_addr(u_addr_s), .bl(bl_s),
        .xfer_done(1'b0), .ref_req(ref_req_s), .ref_ack(ref_ack_s),
        .ref_ovf(ref_ovf_s)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Controller model: acknowledge a refresh one cycle after it is seen.
    initial begin
        ref_ack = 1'b0;
        forever begin
            @(negedge clk);
            ref_ack = auto_ack && ref_req;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int low;
        int exp_id;
        logic seen;

        exp_addr[0] = 23'h12345; exp_bl[0] = 9'd4;   exp_wr_n[0] = 1'b0;
        exp_addr[1] = 23'h2ABCD; exp_bl[1] = 9'd1;   exp_wr_n[1] = 1'b1;
        exp_addr[2] = 23'h7FFFF; exp_bl[2] = 9'd511; exp_wr_n[2] = 1'b0;

        reset1_n    = 1'b0;
        init_done   = 1'b0;
        req         = 3'b000;
        req_wr_n    = 3'b111;
        req_addr    = '0;
        req_bl      = '0;
        xfer_done   = 1'b0;
        init_done_s = 1'b0;
        ref_ack_s   = 1'b0;
        repeat (3) cyc();
        check("reset_outputs",
              {gnt, gnt_id, sdr_req, sdr_req_wr_n, u_addr, bl, ref_req, ref_ovf}, 0);
        reset1_n = 1'b1;

        // init_done low: no grants, no refresh even past one interval.
        req  = 3'b001;
        seen = 1'b0;
        repeat (20) begin
            cyc();
            seen = seen | sdr_req | ref_req | (|gnt);
        end
        check("no_init_activity", seen, 0);
        req = 3'b000;

        // First refresh 17 cycles after init_done rises.
        init_done = 1'b1;
        n = 0;
        while (!ref_req && n < 40) begin
            cyc();
            n++;
        end
        check("ref_first_latency", n, 17);
        auto_ack = 1'b1;
        n = 0;
        while (ref_req && n < 5) begin
            cyc();
            n++;
        end
        check("ref_ack_drops_req", ref_req, 0);
        seen = 1'b0;
        repeat (6) begin
            cyc();
            seen = seen | ref_req;
        end
        check("ref_pend_empty", seen, 0);

        // Single write transfer from requester 0.
        init_done = 1'b0;
        cyc();
        init_done = 1'b1;
        req_addr  = {exp_addr[2], exp_addr[1], exp_addr[0]};
        req_bl    = {exp_bl[2], exp_bl[1], exp_bl[0]};
        req_wr_n  = {exp_wr_n[2], exp_wr_n[1], exp_wr_n[0]};
        req       = 3'b001;
        cyc();
        check("t1_grant", {gnt, gnt_id, sdr_req}, {3'b001, 2'd0, 1'b1});
        check("t1_fields", {u_addr, sdr_req_wr_n, bl}, {23'h12345, 1'b0, 9'd4});
        req = 3'b000;
        cyc();
        check("t1_gnt_pulse", {gnt, sdr_req}, {3'b000, 1'b1});
        repeat (3) cyc();
        check("t1_hold", {sdr_req, u_addr, sdr_req_wr_n, bl},
              {1'b1, 23'h12345, 1'b0, 9'd4});
        xfer_done = 1'b1;
        cyc();
        xfer_done = 1'b0;
        check("t1_gap0", sdr_req, 0);
        cyc();
        check("t1_gap1", sdr_req, 0);

        // All three requesting continuously after a fresh reset.
        reset1_n = 1'b0;
        cyc();
        reset1_n = 1'b1;
        req = 3'b111;
        for (int g = 0; g < 6; g++) begin
            low = 0;
            n   = 0;
            while (gnt == 3'b000 && n < 60) begin
                if (!sdr_req) low++;
                cyc();
                n++;
            end
            exp_id = FIXED ? 0 : (g % 3);
            check($sformatf("rr_gnt%0d", g), {gnt, gnt_id},
                  {3'b001 << exp_id, 2'(exp_id)});
            check($sformatf("rr_fields%0d", g),
                  {sdr_req, u_addr, sdr_req_wr_n, bl},
                  {1'b1, exp_addr[exp_id], exp_wr_n[exp_id], exp_bl[exp_id]});
            if (g > 0) check($sformatf("rr_gap%0d", g), (low >= 2), 1);
            repeat (5) cyc();
            check($sformatf("rr_busy%0d", g), {sdr_req, u_addr},
                  {1'b1, exp_addr[exp_id]});
            xfer_done = 1'b1;
            cyc();
            xfer_done = 1'b0;
        end
        req = 3'b000;

        // Refresh token arrives during BUSY; it is served before requester 1.
        init_done = 1'b0;
        cyc();
        init_done = 1'b1;
        req = 3'b001;
        cyc();
        check("rb_gnt0", gnt, 3'b001);
        req = 3'b010;
        repeat (18) cyc();
        check("rb_busy", {sdr_req, ref_req}, {1'b1, 1'b0});
        xfer_done = 1'b1;
        cyc();
        xfer_done = 1'b0;
        n = 0;
        while (!ref_req && gnt == 3'b000 && n < 20) begin
            cyc();
            n++;
        end
        check("rb_ref_first", {ref_req, gnt}, {1'b1, 3'b000});
        n = 0;
        while (gnt == 3'b000 && n < 20) begin
            cyc();
            n++;
        end
        check("rb_gnt1", {gnt, gnt_id, u_addr}, {3'b010, 2'd1, exp_addr[1]});
        req = 3'b000;

        // Asynchronous reset in the middle of requester 1's transfer.
        cyc();
        check("pre_reset_busy", sdr_req, 1);
        #2 reset1_n = 1'b0;
        #1 check("async_reset", {sdr_req, gnt, ref_req, gnt_id, u_addr}, 0);
        cyc();
        reset1_n = 1'b1;
        req = 3'b111;
        cyc();
        check("post_reset_first", {gnt, gnt_id}, {3'b001, 2'd0});
        req = 3'b000;
        repeat (2) cyc();
        xfer_done = 1'b1;
        cyc();
        xfer_done = 1'b0;
        check("main_no_ovf", ref_ovf, 0);

        // Saturation on a second instance with refresh never acknowledged.
        init_done_s = 1'b1;
        n = 0;
        while (!ref_ovf_s && n < 1000) begin
            cyc();
            n++;
        end
        check("sat_ovf_cycle", n, 320);
        for (int k = 0; k < 7; k++) begin
            n = 0;
            while (!ref_req_s && n < 10) begin
                cyc();
                n++;
            end
            check($sformatf("sat_ref%0d", k), ref_req_s, 1);
            ref_ack_s = 1'b1;
            cyc();
            ref_ack_s = 1'b0;
        end
        seen = 1'b0;
        repeat (10) begin
            cyc();
            seen = seen | ref_req_s;
        end
        check("sat_drained", seen, 0);
        check("sat_ovf_sticky", ref_ovf_s, 1);
        check("sat_host_idle",
              {gnt_s, gnt_id_s, sdr_req_s, sdr_req_wr_n_s, u_addr_s, bl_s}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
